// File: rtl/id_ex_stage_if.sv
// Bundle between the decode slot and the ID/EX pipeline register.
// slave is the stage's own view; master is the view of its surroundings.
interface id_ex_stage_if #(
  parameter int DATA_W = 16
);
  logic              id_valid;
  logic [3:0]        id_src1;
  logic [3:0]        id_src2;
  logic [3:0]        id_dst;
  logic              id_uses_src2;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic              flush;
  logic              ex_stall;
  logic              stall_id;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [3:0]        ex_src1;
  logic [3:0]        ex_src2;
  logic [3:0]        ex_dst;
  logic [3:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_data1;
  logic [DATA_W-1:0] ex_data2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic [15:0]       bubble_count;

  modport slave (
    input  id_valid, id_src1, id_src2, id_dst, id_uses_src2,
    input  id_reg_write, id_mem_read, id_mem_write, id_alu_op,
    input  id_imm, id_pc, SrcData1, SrcData2, flush, ex_stall,
    output stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_src1, ex_src2, ex_dst, ex_alu_op,
    output ex_data1, ex_data2, ex_imm, ex_pc, bubble_count
  );

  modport master (
    output id_valid, id_src1, id_src2, id_dst, id_uses_src2,
    output id_reg_write, id_mem_read, id_mem_write, id_alu_op,
    output id_imm, id_pc, SrcData1, SrcData2, flush, ex_stall,
    input  stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_src1, ex_src2, ex_dst, ex_alu_op,
    input  ex_data1, ex_data2, ex_imm, ex_pc, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and
// downstream stall handling, plus a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  logic              ex_valid_q,     ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic [3:0]        ex_src1_q,      ex_src1_d;
  logic [3:0]        ex_src2_q,      ex_src2_d;
  logic [3:0]        ex_dst_q,       ex_dst_d;
  logic [3:0]        ex_alu_op_q,    ex_alu_op_d;
  logic [DATA_W-1:0] ex_data1_q,     ex_data1_d;
  logic [DATA_W-1:0] ex_data2_q,     ex_data2_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [DATA_W-1:0] ex_pc_q,        ex_pc_d;
  logic [15:0]       bubble_q,       bubble_d;
  logic              hazard;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only a load sitting in EX can create a load-use hazard; after one bubble
  // EX no longer holds it, so the waiting instruction issues on the next edge.
  always_comb begin
    hazard = bus.id_valid & ex_valid_q & ex_mem_read_q &
             ((ex_dst_q == bus.id_src1) |
              (bus.id_uses_src2 & (ex_dst_q == bus.id_src2)));
  end

  assign bus.stall_id = bus.ex_stall | (hazard & ~bus.flush);

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_mem_write_d = ex_mem_write_q;
    ex_src1_d      = ex_src1_q;
    ex_src2_d      = ex_src2_q;
    ex_dst_d       = ex_dst_q;
    ex_alu_op_d    = ex_alu_op_q;
    ex_data1_d     = ex_data1_q;
    ex_data2_d     = ex_data2_q;
    ex_imm_d       = ex_imm_q;
    ex_pc_d        = ex_pc_q;
    bubble_d       = bubble_q;
    if (bus.flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
    end else if (bus.ex_stall) begin
      // hold everything
    end else if (hazard) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      bubble_d       = sat_inc16(bubble_q);
    end else begin
      ex_valid_d     = bus.id_valid;
      ex_reg_write_d = bus.id_valid & bus.id_reg_write;
      ex_mem_read_d  = bus.id_valid & bus.id_mem_read;
      ex_mem_write_d = bus.id_valid & bus.id_mem_write;
      ex_src1_d      = bus.id_src1;
      ex_src2_d      = bus.id_src2;
      ex_dst_d       = bus.id_dst;
      ex_alu_op_d    = bus.id_alu_op;
      ex_data1_d     = bus.SrcData1;
      ex_data2_d     = bus.SrcData2;
      ex_imm_d       = bus.id_imm;
      ex_pc_d        = bus.id_pc;
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_src1_q      <= '0;
      ex_src2_q      <= '0;
      ex_dst_q       <= '0;
      ex_alu_op_q    <= '0;
      ex_data1_q     <= '0;
      ex_data2_q     <= '0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      bubble_q       <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_src1_q      <= ex_src1_d;
      ex_src2_q      <= ex_src2_d;
      ex_dst_q       <= ex_dst_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_data1_q     <= ex_data1_d;
      ex_data2_q     <= ex_data2_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      bubble_q       <= bubble_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_mem_write = ex_mem_write_q;
  assign bus.ex_src1      = ex_src1_q;
  assign bus.ex_src2      = ex_src2_q;
  assign bus.ex_dst       = ex_dst_q;
  assign bus.ex_alu_op    = ex_alu_op_q;
  assign bus.ex_data1     = ex_data1_q;
  assign bus.ex_data2     = ex_data2_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.bubble_count = bubble_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle reference model of the EX slot
// plus hand-computed literal expectations for the key scenarios.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(16)) bus ();
  id_ex_stage #(.DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [3:0]  s1, s2, d, op;
    logic [15:0] d1, d2, imm, pc;
  } ex_t;

  ex_t m;
  bit  m_known = 1'b0;
  bit  m_live  = 1'b0;
  int  m_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input ex_t e);
    return bus.id_valid && e.v && e.mr &&
           (e.d == bus.id_src1 || (bus.id_uses_src2 && e.d == bus.id_src2));
  endfunction

  // Reference model: advance at each edge from the sampled inputs, then
  // compare every DUT output a little after the edge.
  always @(posedge clk) begin
    bit hz;
    hz = model_hazard(m);
    if (rst) begin
      m = '0; m_known = 1'b1; m_cnt = 0; m_live = 1'b1;
    end else if (bus.flush) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m_known = 1'b0;
    end else if (bus.ex_stall) begin
      m = m;
    end else if (hz) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m_known = 1'b0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m.v  = bus.id_valid;
      m.rw = bus.id_valid & bus.id_reg_write;
      m.mr = bus.id_valid & bus.id_mem_read;
      m.mw = bus.id_valid & bus.id_mem_write;
      m.s1 = bus.id_src1;  m.s2 = bus.id_src2;  m.d = bus.id_dst;
      m.op = bus.id_alu_op; m.d1 = bus.SrcData1; m.d2 = bus.SrcData2;
      m.imm = bus.id_imm;  m.pc = bus.id_pc;    m_known = 1'b1;
    end
    #2;
    if (m_live) begin
      chk("m_valid", bus.ex_valid, m.v);
      chk("m_reg_write", bus.ex_reg_write, m.rw);
      chk("m_mem_read", bus.ex_mem_read, m.mr);
      chk("m_mem_write", bus.ex_mem_write, m.mw);
      chk("m_bubble", bus.bubble_count, m_cnt);
      chk("m_stall_id", bus.stall_id, bus.ex_stall | (model_hazard(m) & ~bus.flush));
      if (m_known) begin
        chk("m_src1", bus.ex_src1, m.s1);
        chk("m_src2", bus.ex_src2, m.s2);
        chk("m_dst", bus.ex_dst, m.d);
        chk("m_alu_op", bus.ex_alu_op, m.op);
        chk("m_data1", bus.ex_data1, m.d1);
        chk("m_data2", bus.ex_data2, m.d2);
        chk("m_imm", bus.ex_imm, m.imm);
        chk("m_pc", bus.ex_pc, m.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic u2, input logic rw,
                        input logic mr, input logic mw);
    bus.id_valid = v; bus.id_src1 = s1; bus.id_src2 = s2; bus.id_dst = d;
    bus.id_uses_src2 = u2; bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = mw;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_alu_op = 4'h0; bus.id_imm = 16'h0; bus.id_pc = 16'h0;
    bus.SrcData1 = 16'h0; bus.SrcData2 = 16'h0;
    bus.flush = 1'b0; bus.ex_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_bubble", bus.bubble_count, 0);
    chk("rst_data1", bus.ex_data1, 0);

    // plain issue
    bus.SrcData1 = 16'h1234; bus.id_imm = 16'h0042; bus.id_pc = 16'h0100;
    set_id(1, 1, 2, 3, 0, 1, 0, 0);
    #1 chk("issue_stall", bus.stall_id, 0);
    tick();
    chk("issue_valid", bus.ex_valid, 1);
    chk("issue_dst", bus.ex_dst, 3);
    chk("issue_data1", bus.ex_data1, 16'h1234);
    chk("issue_rw", bus.ex_reg_write, 1);

    // load-use on src1
    set_id(1, 0, 0, 5, 0, 1, 1, 0); tick();
    chk("lu_load_mr", bus.ex_mem_read, 1);
    set_id(1, 5, 0, 6, 0, 1, 0, 0);
    #1 chk("lu_stall", bus.stall_id, 1);
    tick();
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_cnt", bus.bubble_count, 1);
    chk("lu_stall_drop", bus.stall_id, 0);
    tick();
    chk("lu_issue_valid", bus.ex_valid, 1);
    chk("lu_issue_src1", bus.ex_src1, 5);

    // src2 gating
    set_id(1, 0, 0, 7, 0, 1, 1, 0); tick();
    set_id(1, 1, 7, 8, 0, 1, 0, 0);
    #1 chk("s2_nouse_stall", bus.stall_id, 0);
    tick();
    chk("s2_nouse_valid", bus.ex_valid, 1);
    chk("s2_nouse_cnt", bus.bubble_count, 1);
    set_id(1, 0, 0, 7, 0, 1, 1, 0); tick();
    set_id(1, 1, 7, 8, 1, 1, 0, 0);
    #1 chk("s2_use_stall", bus.stall_id, 1);
    tick();
    chk("s2_use_valid", bus.ex_valid, 0);
    chk("s2_use_cnt", bus.bubble_count, 2);
    tick();
    chk("s2_issue_src2", bus.ex_src2, 7);

    // flush beats ex_stall and hazard
    set_id(1, 0, 0, 5, 0, 1, 1, 0); tick();
    set_id(1, 5, 0, 6, 0, 1, 0, 1);
    bus.flush = 1'b1; bus.ex_stall = 1'b1;
    #1 chk("fl_stall_id", bus.stall_id, 1);
    tick();
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_mr", bus.ex_mem_read, 0);
    chk("fl_cnt", bus.bubble_count, 2);
    bus.flush = 1'b0; bus.ex_stall = 1'b0;
    set_id(1, 0, 0, 5, 0, 1, 1, 0); tick();
    set_id(1, 5, 0, 6, 0, 1, 0, 0);
    bus.flush = 1'b1;
    #1 chk("fl2_stall_id", bus.stall_id, 0);
    tick();
    chk("fl2_valid", bus.ex_valid, 0);
    chk("fl2_cnt", bus.bubble_count, 2);
    bus.flush = 1'b0;

    // ex_stall hold
    bus.SrcData2 = 16'hBEEF; bus.id_alu_op = 4'hA;
    set_id(1, 4, 4, 9, 1, 1, 0, 1); tick();
    chk("hold_load_d2", bus.ex_data2, 16'hBEEF);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 4'(i), 4'(i + 1), 4'(i + 2), 1, 0, 1, 0);
      bus.SrcData2 = 16'(i); bus.id_alu_op = 4'(i);
      #1 chk("hold_stall_id", bus.stall_id, 1);
      tick();
      chk("hold_d2", bus.ex_data2, 16'hBEEF);
      chk("hold_dst", bus.ex_dst, 9);
      chk("hold_op", bus.ex_alu_op, 4'hA);
    end

    // reset during stall
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_valid", bus.ex_valid, 0);
    chk("rs_d2", bus.ex_data2, 0);
    chk("rs_mw", bus.ex_mem_write, 0);
    chk("rs_cnt", bus.bubble_count, 0);
    bus.ex_stall = 1'b0;

    // id_valid gating and register 0 hazard
    set_id(0, 0, 0, 0, 0, 1, 1, 1); tick();
    chk("gate_rw", bus.ex_reg_write, 0);
    chk("gate_mr", bus.ex_mem_read, 0);
    set_id(1, 3, 0, 0, 0, 1, 1, 0); tick();
    set_id(1, 0, 0, 2, 0, 1, 0, 0);
    #1 chk("r0_stall", bus.stall_id, 1);
    tick();
    chk("r0_cnt", bus.bubble_count, 1);

    // back-to-back load-use bubbles, then saturation
    set_id(1, 5, 0, 5, 0, 1, 1, 0);
    repeat (12) tick();
    chk("bb_cnt", bus.bubble_count, 7);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
    force dut.bubble_q = 16'hFFFD;
    m_cnt = 65533;
    tick();
    release dut.bubble_q;
    set_id(1, 5, 0, 5, 0, 1, 1, 0);
    repeat (4) tick();
    chk("sat_reach", bus.bubble_count, 16'hFFFF);
    repeat (4) tick();
    chk("sat_hold", bus.bubble_count, 16'hFFFF);
    bus.ex_stall = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("sat_rst_cnt", bus.bubble_count, 0);
    chk("sat_rst_valid", bus.ex_valid, 0);
    bus.ex_stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
